// File: rtl/aes_inv_sub_shift_pkg.sv
// Shared widths, FSM state encoding and byte-position helpers for the
// AES decrypt-side InvShiftRows/InvSubBytes stage.
package aes_inv_sub_shift_pkg;

  localparam int unsigned AES_BLOCK_W = 128;
  localparam int unsigned AES_WORD_W  = 32;
  localparam int unsigned AES_BYTE_W  = 8;
  localparam int unsigned NUM_ROWS    = 4;
  localparam int unsigned NUM_COLS    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // MSB position of state byte s[r][c]; byte i = 4c + r sits at [127-8i -: 8].
  function automatic int unsigned byte_msb(input int unsigned r, input int unsigned c);
    return AES_BLOCK_W - 1 - AES_BYTE_W * (NUM_ROWS * c + r);
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational 32-bit inverse S-box lane: four parallel FIPS-197 inverse
// byte lookups, port-compatible with the forward S-box word lane.
module aes_inv_sbox
  import aes_inv_sub_shift_pkg::*;
(
  input  logic [AES_WORD_W-1:0] sboxw,
  output logic [AES_WORD_W-1:0] new_sboxw
);

  // Entry x lives at bits [(255-x)*8 +: 8], i.e. table reads left to right.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [AES_BYTE_W-1:0] inv_byte(input logic [AES_BYTE_W-1:0] b);
    return INV_SBOX[(255 - int'(b)) * 8 +: 8];
  endfunction

  always_comb begin
    new_sboxw = '0;
    for (int unsigned i = 0; i < AES_WORD_W / AES_BYTE_W; i++)
      new_sboxw[i*AES_BYTE_W +: AES_BYTE_W] = inv_byte(sboxw[i*AES_BYTE_W +: AES_BYTE_W]);
  end

endmodule

// File: rtl/aes_inv_sub_shift.sv
// Iterative InvShiftRows + InvSubBytes: shifts on acceptance, then pushes one
// column per cycle through a single inverse S-box lane; valid/ready both sides.
module aes_inv_sub_shift
  import aes_inv_sub_shift_pkg::*;
#(
  parameter bit SHIFT_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_block,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_block
);

  state_t                 state;
  logic [1:0]             ctr;
  logic [AES_BLOCK_W-1:0] work;
  logic [AES_BLOCK_W-1:0] shifted;
  logic [AES_BLOCK_W-1:0] next_work;
  logic [AES_WORD_W-1:0]  sub_in;
  logic [AES_WORD_W-1:0]  sub_out;

  always_comb begin
    shifted = in_block;
    if (SHIFT_EN) begin
      for (int unsigned c = 0; c < NUM_COLS; c++)
        for (int unsigned r = 0; r < NUM_ROWS; r++)
          shifted[byte_msb(r, c) -: AES_BYTE_W] =
            in_block[byte_msb(r, (c + NUM_COLS - r) % NUM_COLS) -: AES_BYTE_W];
    end
  end

  always_comb begin
    sub_in = work[127:96];
    case (ctr)
      2'd0: sub_in = work[127:96];
      2'd1: sub_in = work[95:64];
      2'd2: sub_in = work[63:32];
      2'd3: sub_in = work[31:0];
      default: sub_in = work[127:96];
    endcase
  end

  aes_inv_sbox u_inv_sbox (
    .sboxw    (sub_in),
    .new_sboxw(sub_out)
  );

  always_comb begin
    next_work = work;
    case (ctr)
      2'd0: next_work[127:96] = sub_out;
      2'd1: next_work[95:64]  = sub_out;
      2'd2: next_work[63:32]  = sub_out;
      2'd3: next_work[31:0]   = sub_out;
      default: next_work = work;
    endcase
  end

  // out_block is its own register so it holds after the handshake while
  // work is being overwritten by the next block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ctr       <= '0;
      work      <= '0;
      out_block <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            work     <= shifted;
            ctr      <= '0;
            in_ready <= 1'b0;
            state    <= ST_SUB;
          end
        end
        ST_SUB: begin
          work <= next_work;
          ctr  <= ctr + 2'd1;
          if (ctr == 2'd3) begin
            out_block <= next_work;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_sub_shift.sv
// Directed bench for aes_inv_sub_shift: one instance with InvShiftRows, one in
// substitution-only mode, driven in lockstep from shared inputs.
module tb_aes_inv_sub_shift;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_block = '0;
  logic         in_ready_s, out_valid_s, in_ready_b, out_valid_b;
  logic [127:0] out_block_s, out_block_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  aes_inv_sub_shift #(.SHIFT_EN(1'b1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_block(in_block),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_block(out_block_s)
  );

  aes_inv_sub_shift #(.SHIFT_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_block(in_block),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_block(out_block_b)
  );

  localparam logic [2047:0] FWD_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] fwd(input logic [7:0] b);
    return FWD_SBOX[(255 - int'(b)) * 8 +: 8];
  endfunction

  // Inverse derived by searching the forward table.
  function automatic logic [7:0] inv(input logic [7:0] b);
    for (int i = 0; i < 256; i++)
      if (fwd(8'(i)) == b) return 8'(i);
    return 8'h00;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] blk, input bit shift);
    logic [127:0] s;
    s = blk;
    if (shift)
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[127 - 8*(4*c + r) -: 8] = blk[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
    for (int i = 0; i < 16; i++)
      s[127 - 8*i -: 8] = inv(s[127 - 8*i -: 8]);
    return s;
  endfunction

  function automatic logic [127:0] fwd_block(input logic [127:0] blk);
    logic [127:0] s;
    for (int i = 0; i < 16; i++)
      s[127 - 8*i -: 8] = fwd(blk[127 - 8*i -: 8]);
    return s;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!out_valid_s && n < 20) begin
      check({tag, " in_ready_s busy"}, 128'(in_ready_s), 128'(1'b0));
      check({tag, " in_ready_b busy"}, 128'(in_ready_b), 128'(1'b0));
      tick();
      n++;
    end
    check({tag, " latency"}, 128'(n), 128'(4));
    check({tag, " out_valid_b"}, 128'(out_valid_b), 128'(1'b1));
  endtask

  // One full transaction: accept, wait for DONE, sample result, handshake.
  task automatic run_block(input string tag, input logic [127:0] blk,
                           output logic [127:0] obs_s, output logic [127:0] obs_b);
    int n;
    n = 0;
    while (!in_ready_s && n < 20) begin
      tick();
      n++;
    end
    in_block = blk;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_done(tag);
    obs_s = out_block_s;
    obs_b = out_block_b;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " out_valid drop"}, 128'(out_valid_s), 128'(1'b0));
    check({tag, " in_ready back"}, 128'(in_ready_s), 128'(1'b1));
  endtask

  initial begin
    logic [127:0] os, ob, blk, held, blk_b;
    logic [127:0] blks [8];
    int n, acc, prev;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset in_ready", 128'(in_ready_s), 128'(1'b1));
    check("reset out_valid", 128'(out_valid_s), 128'(1'b0));
    check("reset out_block_s", out_block_s, 128'h0);
    check("reset out_block_b", out_block_b, 128'h0);

    // Single-byte values; equal columns make the shift a no-op
    run_block("bytes", {4{32'h637c1600}}, os, ob);
    check("bytes b", ob, {4{32'h0001ff52}});
    check("bytes s", os, {4{32'h0001ff52}});

    // FIPS-197 round-1 state
    blk = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    run_block("fips", blk, os, ob);
    check("fips s", os, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    check("fips b", ob, model(blk, 1'b0));

    // All 256 byte values through the bypass instance
    for (int k = 0; k < 64; k++) begin
      logic [31:0] w;
      w = {8'(4*k), 8'(4*k + 1), 8'(4*k + 2), 8'(4*k + 3)};
      blk = {4{w}};
      run_block("exh", blk, os, ob);
      check("exh fwd(out)", fwd_block(ob), blk);
      check("exh s", os, model(blk, 1'b1));
    end

    // Backpressure with a second block waiting
    blk   = 128'h00112233445566778899aabbccddeeff;
    blk_b = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    in_block = blk;
    in_valid = 1'b1;
    tick();
    in_block = blk_b;
    wait_done("bp");
    held = out_block_s;
    check("bp data", held, model(blk, 1'b1));
    for (int i = 0; i < 10; i++) begin
      check("bp out_valid held", 128'(out_valid_s), 128'(1'b1));
      check("bp out_block held", out_block_s, held);
      check("bp in_ready low", 128'(in_ready_s), 128'(1'b0));
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp handshake out_valid", 128'(out_valid_s), 128'(1'b0));
    check("bp handshake in_ready", 128'(in_ready_s), 128'(1'b1));
    check("bp out_block kept", out_block_s, held);
    tick();
    in_valid = 1'b0;
    check("bp second accepted", 128'(in_ready_s), 128'(1'b0));
    wait_done("bp2");
    check("bp2 s", out_block_s, model(blk_b, 1'b1));
    check("bp2 b", out_block_b, model(blk_b, 1'b0));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset coinciding with in_valid: nothing captured
    in_block = blk;
    in_valid = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst+valid in_ready", 128'(in_ready_s), 128'(1'b1));
    repeat (6) tick();
    check("rst+valid no output", 128'(out_valid_s), 128'(1'b0));

    // Reset in the middle of substitution
    in_block = 128'hcafebabedeadbeef0123456789abcdef;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst in_ready", 128'(in_ready_s), 128'(1'b1));
    check("midrst out_valid", 128'(out_valid_s), 128'(1'b0));
    check("midrst out_block_s", out_block_s, 128'h0);
    check("midrst out_block_b", out_block_b, 128'h0);
    repeat (5) begin
      check("midrst no emission", 128'(out_valid_s), 128'(1'b0));
      tick();
    end
    blk = 128'h3925841d02dc09fbdc118597196a0b32;
    run_block("midrst next", blk, os, ob);
    check("midrst next s", os, model(blk, 1'b1));
    check("midrst next b", ob, model(blk, 1'b0));

    // Back-to-back streaming
    for (int k = 0; k < 8; k++) blks[k] = {$urandom, $urandom, $urandom, $urandom};
    in_valid  = 1'b1;
    out_ready = 1'b1;
    prev = 0;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      in_block = blks[k];
      n = 0;
      while (!in_ready_s && n < 20) begin
        tick();
        acc++;
        n++;
      end
      tick();
      acc++;
      if (k > 0) check("stream period", 128'(acc - prev), 128'(6));
      prev = acc;
      n = 0;
      while (!out_valid_s && n < 20) begin
        tick();
        acc++;
        n++;
      end
      check("stream latency", 128'(n), 128'(4));
      check("stream s", out_block_s, model(blks[k], 1'b1));
      check("stream b", out_block_b, model(blks[k], 1'b0));
      tick();
      acc++;
      if (k == 7) in_valid = 1'b0;
      check("stream pulse", 128'(out_valid_s), 128'(1'b0));
    end
    out_ready = 1'b0;
    repeat (8) tick();
    check("stream no duplicate", 128'(out_valid_s), 128'(1'b0));
    check("stream idle", 128'(in_ready_s), 128'(1'b1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aes_inv_sub_shift.md
Name: aes_inv_sub_shift

Overview:
- Decryption-side byte-substitution stage: applies AES InvShiftRows then InvSubBytes to a 128-bit state.
- Reuses one 32-bit inverse S-box lane iteratively: one column per cycle, 4 cycles per block.
- Sits in the decrypt datapath between AddRoundKey and InvMixColumns, and is the counterpart of the forward 32-bit S-box used by encryption and key expansion.
- Valid/ready handshake on both input and output.

Parameters:
- SHIFT_EN, 1: 1 = apply InvShiftRows before substitution; 0 = substitution only (bypass, for final-round debug).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  in_block is valid.
- in_ready  out  1  block can accept input (high only in IDLE).
- in_block  in  128  AES state; byte i = in_block[127-8i -: 8], column c = bytes 4c..4c+3, row r = i mod 4.
- out_valid  out  1  out_block is valid.
- out_ready  in  1  downstream accepts out_block.
- out_block  out  128  InvSubBytes(InvShiftRows(in_block)), same byte ordering.

Behaviour:
- Reset: a synchronous reset with rst=1 at any edge forces the following.
  - State is IDLE, in_ready=1, out_valid=0, out_block=0, word counter=0.
  - Any in-flight block is discarded and no partial result is emitted.
- InvShiftRows: s'[r][c] = s[r][(c - r) mod 4]. It is applied combinationally on in_block and captured into the working register at acceptance.
- FSM IDLE:
  - in_ready=1.
  - On in_valid at an edge, capture the shifted state, set ctr=0 and go to SUB.
- FSM SUB:
  - in_ready=0.
  - Each edge replaces working word ctr (bits [127-32*ctr -: 32]) with aes_inv_sbox(word), then ctr increments.
  - After the edge with ctr=3, go to DONE.
- FSM DONE:
  - out_valid=1 and out_block=working register.
  - out_block must stay stable while out_ready=0.
  - When out_ready=1 at an edge, go to IDLE with out_valid=0.
- Latency: acceptance edge T, then SUB edges T+1..T+4. out_valid is high from after edge T+4. Minimum period is 6 cycles per block (accept, 4×SUB, output handshake).
- in_valid is ignored outside IDLE; no input is lost because in_ready=0 there.
- out_ready is ignored outside DONE.
- An out_ready held high permanently gives a one-cycle out_valid pulse.
- Counter: 2 bits, wraps 3→0 on leaving SUB. No other wrap is reachable.
- rst and in_valid asserted on the same edge: rst wins and nothing is captured.
- SHIFT_EN=0: the capture is in_block unmodified, with identical timing.
- out_block keeps its last value after the output handshake until the next DONE (do not clear it).

Decomposition:
- Shared package/include (aes_defs):
  - AES_BLOCK_W=128, AES_WORD_W=32, AES_BYTE_W=8.
  - FSM encodings ST_IDLE=2'd0, ST_SUB=2'd1, ST_DONE=2'd2.
  - Byte-index helper constants for row/column mapping.
- Sub-module aes_inv_sbox:
  - Combinational, port sboxw[31:0] → new_sboxw[31:0].
  - 256-entry FIPS-197 inverse table, applied to 4 bytes in parallel.
  - Mirrors the forward S-box interface so the two are interchangeable in the datapath.
  - The top instantiates it exactly once.

Test Plan:
- Reset, then single-byte checks: in_block=63 7c 16 00 repeated (SHIFT_EN=0). Required out_block=00 01 ff 52 repeated, with out_valid 4 cycles after acceptance.
- FIPS-197 App. B round 1 inverse: in_block=d4bf5d30e0b452aeb84111f11e2798e5 (SHIFT_EN=1). Required out_block=193de3bea0f4e22b9ac68d2ae9f84808.
- Exhaustive inverse check: feed all 256 byte values (64 blocks, SHIFT_EN=0), apply forward S-box to each output. The result must equal the original input; in_ready must be 0 throughout SUB/DONE.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. Required: out_valid stays 1, out_block is unchanged, and in_ready=0 while in_valid=1 (second block not accepted until after the handshake).
- Mid-operation reset: assert rst during SUB cycle 2. Required: the next cycle is IDLE, out_valid=0, out_block=0, in_ready=1; the next block is processed correctly.
- Back-to-back streaming: 8 random blocks with in_valid and out_ready held high. Required: every output matches the reference model, each block takes exactly 6 cycles, and blocks are neither dropped nor duplicated.
